// File: rtl/digit_scan_decoder_if.sv
// Digit scan bus: scan enable and per-digit mask in,
// position select, digit index and frame marker out.
interface digit_scan_decoder_if #(
  parameter int DIGITS = 5,
  parameter int IDX_W  = 3
);
  logic              en;
  logic [DIGITS-1:0] blank_mask;
  logic [DIGITS-1:0] position;
  logic [IDX_W-1:0]  digit_idx;
  logic              frame_start;

  modport master (
    output en,
    output blank_mask,
    input  position,
    input  digit_idx,
    input  frame_start
  );

  modport slave (
    input  en,
    input  blank_mask,
    output position,
    output digit_idx,
    output frame_start
  );
endinterface

// File: rtl/digit_scan_decoder.sv
// Time-multiplexed 7-seg digit select with a blanking gap
// before every digit and per-digit masking.
module digit_scan_decoder #(
  parameter int DIGITS     = 5,
  parameter int IDX_W      = 3,
  parameter int DWELL      = 1000,
  parameter int BLANK      = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  digit_scan_decoder_if.slave  bus
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int BLL  = (BLANK > 0) ? BLANK - 1 : 0;

  localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BL_LAST = CW'(BLL);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  localparam logic [DIGITS-1:0] INACT =
    (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [DIGITS-1:0] ONE =
    DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    SHOW
  } state_t;

  state_t            state;
  state_t            nxt_state;
  state_t            entry_state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     nxt_cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  nxt_idx;
  logic [IDX_W-1:0]  idx_wrap;
  logic [IDX_W-1:0]  slot_idx;
  logic              slot_go;
  logic              fs_q;
  logic              nxt_fs;
  logic              nxt_lit;
  logic [DIGITS-1:0] pos_q;
  logic [DIGITS-1:0] pos_d;

  assign entry_state = (BLANK > 0) ? GAP : SHOW;

  assign idx_wrap = (idx_q == IDX_MAX) ?
                    '0 : idx_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx_q <= '0;
      fs_q  <= 1'b0;
      pos_q <= INACT;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      idx_q <= nxt_idx;
      fs_q  <= nxt_fs;
      pos_q <= pos_d ^ INACT;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 1'b1;
    nxt_idx   = idx_q;
    nxt_fs    = 1'b0;
    slot_go   = 1'b0;
    slot_idx  = '0;

    unique case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (bus.en) begin
          slot_go  = 1'b1;
          slot_idx = '0;
        end
      end
      GAP: begin
        if (cnt == BL_LAST) begin
          nxt_state = SHOW;
          nxt_cnt   = '0;
        end
      end
      SHOW: begin
        if (cnt == DW_LAST) begin
          slot_go  = 1'b1;
          slot_idx = idx_wrap;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
        nxt_idx   = '0;
      end
    endcase

    // every slot starts with a fresh count; digit 0 marks the frame
    if (slot_go) begin
      nxt_state = entry_state;
      nxt_cnt   = '0;
      nxt_idx   = slot_idx;
      nxt_fs    = (slot_idx == '0);
    end

    if (!bus.en) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
      nxt_idx   = '0;
      nxt_fs    = 1'b0;
    end
  end

  // select is built from the next state so it lines up with SHOW
  always_comb begin
    nxt_lit = (nxt_state == SHOW) &&
              !bus.blank_mask[nxt_idx];
    pos_d   = '0;
    if (nxt_lit) begin
      pos_d = ONE << nxt_idx;
    end
  end

  assign bus.position    = pos_q;
  assign bus.digit_idx   = idx_q;
  assign bus.frame_start = fs_q;

endmodule
